// File: rtl/booth_pp_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : booth_pp_accumulator
// Purpose  : Iterative accumulator for radix-4 Booth partial products. Each
//            product is weighted by 4^k and summed into a 2N-bit result.
//            Optional protocol checker: define BOOTH_PP_ACC_ERRCHK_EN.
// Revision : 1.0  initial release
// ============================================================================
module booth_pp_accumulator #(
    parameter int N = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pp_valid,
    output logic             pp_ready,
    input  logic [N:0]       pp_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   product,
    output logic             busy,
    output logic             pp_err
);

    localparam int c_P  = N / 2;
    localparam int c_KW = $clog2(c_P) + 1;
    localparam logic [c_KW-1:0] c_KLAST = c_KW'(c_P - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [2*N-1:0]     r_acc;
    logic [c_KW-1:0]    r_k;
    logic               r_pp_ready;
    logic               r_out_valid;
    logic               r_busy;

    logic               w_accept;
    logic [2*N-1:0]     w_pp_ext;
    logic [2*N-1:0]     w_pp_shift;

    assign w_accept   = pp_valid & r_pp_ready;
    assign w_pp_ext   = {{(N-1){pp_data[N]}}, pp_data};
    // Weight 4^k is a left shift by 2k.
    assign w_pp_shift = w_pp_ext << {r_k, 1'b0};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_k         <= '0;
            r_pp_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_ACCUM;
                        r_acc      <= '0;
                        r_k        <= '0;
                        r_pp_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        r_acc <= r_acc + w_pp_shift;
                        r_k   <= r_k + c_KW'(1);
                        if (r_k == c_KLAST) begin
                            r_state     <= S_DONE;
                            r_pp_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_pp_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef BOOTH_PP_ACC_ERRCHK_EN
    logic r_pp_err;

    // An honoured start wins over any violation seen in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pp_err <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_pp_err <= 1'b0;
        end else if ((pp_valid && r_state != S_ACCUM) ||
                     (start && r_state != S_IDLE)) begin
            r_pp_err <= 1'b1;
        end
    end

    assign pp_err = r_pp_err;
`else
    assign pp_err = 1'b0;
`endif

    assign pp_ready  = r_pp_ready;
    assign out_valid = r_out_valid;
    assign product   = r_acc;
    assign busy      = r_busy;

endmodule
`default_nettype wire
